// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: states, opcodes,
// next-PC selects, datapath mux codes and the decoded instruction-class bundle.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned NPC_W   = 3;
    localparam int unsigned ALUOP_W = 3;
    localparam int unsigned EXT_W   = 2;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_EXE   = 4'd2,
        S_ALUWB = 4'd3,
        S_MA    = 4'd4,
        S_MRD   = 4'd5,
        S_MWB   = 4'd6,
        S_MWR   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_INT   = 4'd10
    } state_e;

    localparam logic [NPC_W-1:0] NPC_SEL_PC_ADD_4 = 3'd0;
    localparam logic [NPC_W-1:0] NPC_SEL_REG_JMP  = 3'd1;
    localparam logic [NPC_W-1:0] NPC_SEL_J_JMP    = 3'd2;
    localparam logic [NPC_W-1:0] NPC_SEL_BEQ_JMP  = 3'd3;
    localparam logic [NPC_W-1:0] NPC_SEL_INT_JMP  = 3'd4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
    localparam logic [OP_W-1:0] OP_COP0  = 6'h10;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_ERET  = 6'h18;
    localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd2;

    localparam logic [EXT_W-1:0] EXT_ZERO = 2'd0;
    localparam logic [EXT_W-1:0] EXT_SIGN = 2'd1;
    localparam logic [EXT_W-1:0] EXT_LUI  = 2'd2;

    localparam logic [SEL_W-1:0] WD_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WD_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WD_PC  = 2'd2;

    localparam logic [SEL_W-1:0] RD_RT = 2'd0;
    localparam logic [SEL_W-1:0] RD_RD = 2'd1;
    localparam logic [SEL_W-1:0] RD_RA = 2'd2;

    typedef struct packed {
        logic r_add;
        logic r_sub;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic eret;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flags in, datapath strobes and selects out.
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [31:0]        IR;
    logic               Zero;
    logic               IntReq;
    logic               PCWr;
    logic [NPC_W-1:0]   NPCSel;
    logic               EPCToPC;
    logic               IRWr;
    logic               RegWr;
    logic [SEL_W-1:0]   RegDst;
    logic [SEL_W-1:0]   WdSel;
    logic               ALUSrc;
    logic [EXT_W-1:0]   ExtOp;
    logic [ALUOP_W-1:0] ALUOp;
    logic               MemWr;
    logic               EPCWr;
    logic               EXLSet;
    logic               EXLClr;
    logic               IllegalOp;

    modport master (
        input  IR, Zero, IntReq,
        output PCWr, NPCSel, EPCToPC, IRWr, RegWr, RegDst, WdSel,
               ALUSrc, ExtOp, ALUOp, MemWr, EPCWr, EXLSet, EXLClr, IllegalOp
    );

    modport slave (
        output IR, Zero, IntReq,
        input  PCWr, NPCSel, EPCToPC, IRWr, RegWr, RegDst, WdSel,
               ALUSrc, ExtOp, ALUOp, MemWr, EPCWr, EXLSet, EXLClr, IllegalOp
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Opcode/funct to one-hot instruction class; anything unrecognised flags illegal.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [OP_W-1:0] funct_i,
    output instr_class_t    cls_o
);

    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: cls_o.r_add   = 1'b1;
                    FN_SUBU: cls_o.r_sub   = 1'b1;
                    FN_JR:   cls_o.jr      = 1'b1;
                    default: cls_o.illegal = 1'b1;
                endcase
            end
            OP_COP0: begin
                if (funct_i == FN_ERET) cls_o.eret    = 1'b1;
                else                    cls_o.illegal = 1'b1;
            end
            OP_ORI:  cls_o.ori     = 1'b1;
            OP_LUI:  cls_o.lui     = 1'b1;
            OP_LW:   cls_o.lw      = 1'b1;
            OP_SW:   cls_o.sw      = 1'b1;
            OP_BEQ:  cls_o.beq     = 1'b1;
            OP_J:    cls_o.j       = 1'b1;
            OP_JAL:  cls_o.jal     = 1'b1;
            default: cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences fetch/decode/execute per instruction and
// takes pending interrupts only at instruction boundaries.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.master bus
);

    state_e       state_q, state_d;
    state_e       bnd_next_c;
    instr_class_t cls;
    logic         alu_class_c;
    logic         jmp_class_c;
    logic         ir_unused;

    mc_ctrl_decode u_decode (
        .op_i    (bus.IR[31:26]),
        .funct_i (bus.IR[5:0]),
        .cls_o   (cls)
    );

    assign ir_unused   = ^bus.IR[25:6];
    assign alu_class_c = cls.r_add | cls.r_sub | cls.ori | cls.lui;
    assign jmp_class_c = cls.j | cls.jal | cls.jr | cls.eret;
    assign bnd_next_c  = bus.IntReq ? S_INT : S_FETCH;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                if (alu_class_c)           state_d = S_EXE;
                else if (cls.lw | cls.sw)  state_d = S_MA;
                else if (cls.beq)          state_d = S_BR;
                else if (jmp_class_c)      state_d = S_JMP;
                else                       state_d = bnd_next_c;
            end
            S_EXE:   state_d = S_ALUWB;
            S_MA:    state_d = cls.lw ? S_MRD : S_MWR;
            S_MRD:   state_d = S_MWB;
            S_ALUWB, S_MWB, S_MWR, S_BR, S_JMP: state_d = bnd_next_c;
            S_INT:   state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode; strobes are forced low for the whole reset window.
    always_comb begin
        bus.PCWr      = 1'b0;
        bus.NPCSel    = NPC_SEL_PC_ADD_4;
        bus.EPCToPC   = 1'b0;
        bus.IRWr      = 1'b0;
        bus.RegWr     = 1'b0;
        bus.RegDst    = RD_RT;
        bus.WdSel     = WD_ALU;
        bus.ALUSrc    = 1'b0;
        bus.ExtOp     = EXT_ZERO;
        bus.ALUOp     = ALU_ADD;
        bus.MemWr     = 1'b0;
        bus.EPCWr     = 1'b0;
        bus.EXLSet    = 1'b0;
        bus.EXLClr    = 1'b0;
        bus.IllegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.IRWr   = 1'b1;
                bus.PCWr   = 1'b1;
                bus.NPCSel = NPC_SEL_PC_ADD_4;
            end
            S_DCD: bus.IllegalOp = cls.illegal;
            S_EXE, S_ALUWB: begin
                bus.ALUSrc = cls.ori | cls.lui;
                bus.ExtOp  = cls.lui ? EXT_LUI : EXT_ZERO;
                bus.ALUOp  = cls.r_sub ? ALU_SUB : (cls.ori ? ALU_OR : ALU_ADD);
                if (state_q == S_ALUWB) begin
                    bus.RegWr  = 1'b1;
                    bus.WdSel  = WD_ALU;
                    bus.RegDst = (cls.r_add | cls.r_sub) ? RD_RD : RD_RT;
                end
            end
            S_MA, S_MRD, S_MWR: begin
                bus.ALUSrc = 1'b1;
                bus.ExtOp  = EXT_SIGN;
                bus.ALUOp  = ALU_ADD;
                bus.MemWr  = (state_q == S_MWR);
            end
            S_MWB: begin
                bus.RegWr  = 1'b1;
                bus.RegDst = RD_RT;
                bus.WdSel  = WD_MEM;
            end
            S_BR: begin
                bus.ALUSrc = 1'b0;
                bus.ALUOp  = ALU_SUB;
                bus.PCWr   = bus.Zero;
                bus.NPCSel = NPC_SEL_BEQ_JMP;
            end
            S_JMP: begin
                bus.PCWr = 1'b1;
                if (cls.jr | cls.eret) begin
                    bus.NPCSel  = NPC_SEL_REG_JMP;
                    bus.EPCToPC = cls.eret;
                    bus.EXLClr  = cls.eret;
                end else begin
                    bus.NPCSel = NPC_SEL_J_JMP;
                    if (cls.jal) begin
                        bus.RegWr  = 1'b1;
                        bus.RegDst = RD_RA;
                        bus.WdSel  = WD_PC;
                    end
                end
            end
            S_INT: begin
                bus.EPCWr  = 1'b1;
                bus.EXLSet = 1'b1;
                bus.PCWr   = 1'b1;
                bus.NPCSel = NPC_SEL_INT_JMP;
            end
            default: ;
        endcase
        if (reset) begin
            bus.PCWr      = 1'b0;
            bus.IRWr      = 1'b0;
            bus.RegWr     = 1'b0;
            bus.MemWr     = 1'b0;
            bus.EPCWr     = 1'b0;
            bus.EXLSet    = 1'b0;
            bus.EXLClr    = 1'b0;
            bus.IllegalOp = 1'b0;
        end
    end

endmodule
